// File: rtl/hub75_blanking.sv
// HUB75 blanking engine: after each accepted request, drives a blanked guard,
// an on-window weighted by bit-plane, then a second blanked guard.
module hub75_blanking #(
   parameter int N_PLANES = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                phy_blank,
   input  logic [N_PLANES-1:0] ctrl_plane,
   input  logic                ctrl_go,
   output logic                ctrl_rdy,
   input  logic [7:0]          cfg_bit_len,
   input  logic [7:0]          cfg_guard_len
);

   localparam int CW = 8 + N_PLANES;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRE,
      ST_ON,
      ST_POST
   } stateT;

   stateT               state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N_PLANES-1:0] plane_q, plane_d;
   logic [7:0]          bitLen_q, bitLen_d;
   logic [7:0]          guardLen_q, guardLen_d;
   logic                phyBlank_q;
   logic [CW-1:0]       onLen;

   // A mask read as an integer is the sum of its plane weights, so one product covers multi-bit masks
   assign onLen = CW'(bitLen_q) * CW'(plane_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         plane_q    <= '0;
         bitLen_q   <= '0;
         guardLen_q <= '0;
         phyBlank_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         plane_q    <= plane_d;
         bitLen_q   <= bitLen_d;
         guardLen_q <= guardLen_d;
         phyBlank_q <= (state_d != ST_ON);
      end
   end

   // The counter is reloaded with (length-1) on each state entry and the state exits when it reaches zero
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      plane_d    = plane_q;
      bitLen_d   = bitLen_q;
      guardLen_d = guardLen_q;
      unique case (state_q)
         ST_IDLE: begin
            if (ctrl_go) begin
               plane_d    = ctrl_plane;
               bitLen_d   = cfg_bit_len;
               guardLen_d = cfg_guard_len;
               cnt_d      = CW'(cfg_guard_len);
               state_d    = ST_PRE;
            end
         end
         ST_PRE: begin
            if (cnt_q == '0) begin
               if (onLen != '0) begin
                  cnt_d   = onLen - CW'(1);
                  state_d = ST_ON;
               end else begin
                  cnt_d   = CW'(guardLen_q);
                  state_d = ST_POST;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_ON: begin
            if (cnt_q == '0) begin
               cnt_d   = CW'(guardLen_q);
               state_d = ST_POST;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_POST: begin
            if (cnt_q == '0) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign phy_blank = phyBlank_q;
   assign ctrl_rdy  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_hub75_blanking.sv
// Scoreboard bench for hub75_blanking: each accepted request queues the expected
// per-cycle (phy_blank, ctrl_rdy) trace, which is compared on every falling edge.
module tb_hub75_blanking;

   logic       clk;
   logic       rst_n;
   logic       phy_blank;
   logic [7:0] ctrl_plane;
   logic       ctrl_go;
   logic       ctrl_rdy;
   logic [7:0] cfg_bit_len;
   logic [7:0] cfg_guard_len;

   typedef struct packed {
      logic blank;
      logic rdy;
   } expT;

   expT  expQ[$];
   logic expRdy;
   int   total;
   int   bad;

   hub75_blanking #(.N_PLANES(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .phy_blank    (phy_blank),
      .ctrl_plane   (ctrl_plane),
      .ctrl_go      (ctrl_go),
      .ctrl_rdy     (ctrl_rdy),
      .cfg_bit_len  (cfg_bit_len),
      .cfg_guard_len(cfg_guard_len)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Reference timeline: on-length built as a sum of shifted bit lengths, one entry per busy cycle
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expQ.delete();
      end else if (ctrl_go && expRdy && expQ.size() == 0) begin
         int g;
         int n;
         g = int'(cfg_guard_len) + 1;
         n = 0;
         for (int k = 0; k < 8; k++)
            if (ctrl_plane[k]) n += int'(cfg_bit_len) << k;
         for (int i = 0; i < g; i++) expQ.push_back('{blank: 1'b1, rdy: 1'b0});
         for (int i = 0; i < n; i++) expQ.push_back('{blank: 1'b0, rdy: 1'b0});
         for (int i = 0; i < g; i++) expQ.push_back('{blank: 1'b1, rdy: 1'b0});
      end
   end

   always @(negedge clk) begin
      expT e;
      e = '{blank: 1'b1, rdy: 1'b1};
      if (rst_n && expQ.size() != 0) e = expQ.pop_front();
      expRdy = e.rdy;
      checkOutput("phy_blank", 32'(phy_blank), 32'(e.blank));
      checkOutput("ctrl_rdy", 32'(ctrl_rdy), 32'(e.rdy));
   end

   task automatic waitIdle();
      int n;
      n = 0;
      while (!(expQ.size() == 0 && expRdy) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 3000) checkOutput("idleTimeout", 32'd1, 32'd0);
   endtask

   task automatic applyStimulus(input logic [7:0] plane, input logic [7:0] bitLen,
                                input logic [7:0] guard, input bit scramble);
      ctrl_plane    = plane;
      cfg_bit_len   = bitLen;
      cfg_guard_len = guard;
      ctrl_go       = 1'b1;
      @(posedge clk);
      #1;
      ctrl_go = 1'b0;
      if (scramble) begin
         ctrl_plane    = 8'hFF;
         cfg_bit_len   = 8'hC8;
         cfg_guard_len = 8'h40;
      end
      waitIdle();
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      total         = 0;
      bad           = 0;
      expRdy        = 1'b1;
      rst_n         = 1'b1;
      ctrl_go       = 1'b0;
      ctrl_plane    = 8'h00;
      cfg_bit_len   = 8'h00;
      cfg_guard_len = 8'h00;
      #2;
      rst_n   = 1'b0;
      ctrl_go = 1'b1;
      ctrl_plane  = 8'h01;
      cfg_bit_len = 8'h05;
      repeat (3) @(posedge clk);
      #1;
      ctrl_go = 1'b0;
      rst_n   = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      $display("[TB] single LSB request");
      applyStimulus(8'h01, 8'd4, 8'd1, 1'b0);
      $display("[TB] MSB weighting");
      applyStimulus(8'h80, 8'd3, 8'd0, 1'b0);
      $display("[TB] multi-bit mask");
      applyStimulus(8'h05, 8'd2, 8'd1, 1'b0);
      $display("[TB] zero cases");
      applyStimulus(8'h00, 8'd5, 8'd2, 1'b0);
      applyStimulus(8'h04, 8'd0, 8'd3, 1'b0);
      $display("[TB] cfg change mid-sequence");
      applyStimulus(8'h02, 8'd3, 8'd2, 1'b1);

      $display("[TB] go held high with changing mask");
      cfg_bit_len   = 8'd2;
      cfg_guard_len = 8'd0;
      ctrl_go       = 1'b1;
      for (int i = 0; i < 60; i++) begin
         ctrl_plane = 8'h01 << (i % 3);
         @(posedge clk);
         #1;
      end
      ctrl_go = 1'b0;
      waitIdle();

      $display("[TB] reset mid-ON");
      ctrl_plane    = 8'h10;
      cfg_bit_len   = 8'd100;
      cfg_guard_len = 8'd1;
      ctrl_go       = 1'b1;
      @(posedge clk);
      #1;
      ctrl_go = 1'b0;
      repeat (2 + 50) @(posedge clk);
      #1;
      checkOutput("midOnBlank", 32'(phy_blank), 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncBlank", 32'(phy_blank), 32'd1);
      checkOutput("asyncRdy", 32'(ctrl_rdy), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      applyStimulus(8'h01, 8'd1, 8'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hub75_blanking.md
# hub75_blanking

Blanking engine of the HUB75 driver. It answers the BCM sequencer's blank request (plane mask plus go/ready handshake). For each accepted request it lights the panel for a time proportional to the binary weight of the requested bit-plane, framed by blanked guard intervals. Its `phy_blank` output drives the panel OE path through the PHY.

## Interface

Parameters:
- `N_PLANES`, default 8: number of BCM bit-planes; width of the plane mask.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `phy_blank`, out, 1: 1 = panel LEDs off, 0 = LEDs driven (OE asserted).
- `ctrl_plane`, in, N_PLANES: plane mask from the sequencer, normally one-hot; bit k has weight 2^k.
- `ctrl_go`, in, 1: request strobe; sampled only while `ctrl_rdy` = 1.
- `ctrl_rdy`, out, 1: block idle and able to accept a request.
- `cfg_bit_len`, in, 8: on-time in clk cycles for one LSB unit (plane 0).
- `cfg_guard_len`, in, 8: blanked guard length; each guard lasts `cfg_guard_len`+1 cycles.

## Operation

- The FSM has four states: ST_IDLE, ST_PRE, ST_ON and ST_POST.
- ST_IDLE:
  - `ctrl_rdy` = 1 and `phy_blank` = 1.
  - If `ctrl_go` = 1, the block latches `ctrl_plane`, `cfg_bit_len` and `cfg_guard_len`, then moves to ST_PRE.
- ST_PRE:
  - Blanked for `cfg_guard_len`+1 cycles.
  - Moves to ST_ON if the on-length is nonzero, otherwise to ST_POST.
- ST_ON:
  - `phy_blank` = 0 for exactly on-length cycles, then moves to ST_POST.
- ST_POST:
  - Blanked for `cfg_guard_len`+1 cycles, then moves to ST_IDLE.
- On-length = latched `cfg_bit_len` × latched plane mask, read as an unsigned integer.
  - The result is 8+N_PLANES bits wide, unsigned, and can never overflow.
  - A multi-bit mask gives the sum of its weights.
  - An all-zero mask or `cfg_bit_len` = 0 gives on-length 0, so ST_ON is skipped entirely.
- One down-counter, 8+N_PLANES bits wide, serves all timed states. It is reloaded on every state entry.
- Configuration and mask changes after acceptance have no effect until the next request.
- `ctrl_go` while `ctrl_rdy` = 0 is ignored. It is not queued.
- `phy_blank` is a registered output that is low only while the state is ST_ON. It is glitch-free.

## Timing

- Reset: state ST_IDLE, `phy_blank` = 1, `ctrl_rdy` = 1, counters cleared.
- Reset asserted mid-sequence forces `phy_blank` = 1 immediately (asynchronously) and aborts the sequence.
- Acceptance: `ctrl_go` sampled high at edge T.
  - From T+1, `ctrl_rdy` = 0 and the state is ST_PRE.
- Cycle budget with G = `cfg_guard_len`+1 and N = on-length:
  - `phy_blank` falls at T+1+G.
  - It stays low for N cycles.
  - `ctrl_rdy` returns high at T+1+2G+N.
  - Request-to-ready total: 2G+N+1 cycles.
- Back-to-back requests: `ctrl_go` may be asserted in the first ST_IDLE cycle. The minimum gap is one idle cycle.
- There is never a cycle with `phy_blank` = 0 outside ST_ON, including at the ST_ON→ST_POST boundary.

## Test plan

- Reset, then idle: `rst_n` low for 3 cycles, then high → `phy_blank` = 1 and `ctrl_rdy` = 1 throughout. A `ctrl_go` pulse during reset has no effect.
- Single LSB request: bit_len=4, guard=1, plane=8'h01, `ctrl_go` at T → `phy_blank` low exactly at T+3..T+6, `ctrl_rdy` high again at T+9.
- MSB weighting: bit_len=3, guard=0, plane=8'h80 → `phy_blank` low for exactly 384 consecutive cycles; busy for 387 cycles total.
- Zero cases: plane=8'h00, and separately bit_len=0 → `phy_blank` never drops; `ctrl_rdy` returns after 2G+1 cycles.
- Handshake robustness:
  - `ctrl_go` held high continuously, plane changed mid-sequence → requests accepted only on ST_IDLE cycles, each using the mask latched at acceptance.
  - Changing cfg mid-sequence has no effect on the current sequence.
- Reset mid-ON: bit_len=100, plane=8'h10, `rst_n` low 50 cycles into ST_ON → `phy_blank` = 1 within the same cycle (async). After release, `ctrl_rdy` = 1 and no residual on-time.
